// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, fetches over imem req/ack and drives the {pc, ir, npc, valid} output slot.
// Latency: an accepted request (req & ack) in cycle N shows as if_valid=1 in cycle N+1.
// Backpressure: stall holds a valid slot; a word accepted while the slot is blocked parks in a 1-entry skid.
// Optional fetch-address alignment exception when IF_ALIGN_CHECK_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc,
  output logic        if_exc
);

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic [2:0] {S_RUN, S_WAIT, S_SKID, S_DROP, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_SKID, S_DROP} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_addr;   // address of the abandoned request still owed an ack
  logic [31:0] skid_pc;     // skid occupancy is implied by state == S_SKID
  logic [31:0] skid_ir;
  logic [31:0] tgt_aligned;
  logic        slot_free;
  logic        ld_fetch;
  logic        ld_skid;
  logic        unld_skid;
  logic        pc_inc;
  logic        br_misaligned;

  assign slot_free   = !if_valid || !stall;
  assign tgt_aligned = br_target & ~32'h3;

`ifdef IF_ALIGN_CHECK_EN
  assign br_misaligned = br_taken && (br_target[1:0] != 2'b00);
`else
  assign br_misaligned = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Next state, memory request and datapath strobes; redirect outranks stall and ack
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    ld_fetch  = 1'b0;
    ld_skid   = 1'b0;
    unld_skid = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      S_RUN: begin
        imem_req = slot_free;
        if (br_taken) begin
          state_nxt = S_RUN;
        end else if (slot_free && imem_ack) begin
          ld_fetch = 1'b1;
          pc_inc   = 1'b1;
        end else if (slot_free) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (br_taken) begin
          state_nxt = imem_ack ? S_RUN : S_DROP;
        end else if (imem_ack) begin
          pc_inc = 1'b1;
          if (slot_free) begin
            ld_fetch  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            ld_skid   = 1'b1;
            state_nxt = S_SKID;
          end
        end
      end
      S_SKID: begin
        if (br_taken) begin
          state_nxt = S_RUN;
        end else if (slot_free) begin
          unld_skid = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_DROP: begin
        // keep presenting the old address until the memory acks it; the word is thrown away
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (imem_ack) state_nxt = S_RUN;
      end
`ifdef IF_ALIGN_CHECK_EN
      S_HALT: begin
        if (br_taken && !br_misaligned) state_nxt = S_RUN;
      end
`endif
      default: state_nxt = S_RUN;
    endcase
`ifdef IF_ALIGN_CHECK_EN
    if (br_misaligned) state_nxt = S_HALT;
`endif
    if (reset) imem_req = 1'b0;
  end

  // PC, skid entry and output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      skid_pc   <= RESET_PC;
      skid_ir   <= NOP_INSTR;
      if_valid  <= 1'b0;
      if_pc     <= RESET_PC;
      if_ir     <= NOP_INSTR;
      if_npc    <= RESET_PC + 32'd4;
    end else if (br_taken) begin
      pc       <= tgt_aligned;
      if_valid <= 1'b0;
      if_ir    <= NOP_INSTR;
      if (state == S_WAIT && !imem_ack) drop_addr <= pc;
      if (br_misaligned) begin
        // faulting target is reported through the slot instead of being fetched
        if_valid <= 1'b1;
        if_pc    <= br_target;
        if_npc   <= br_target + 32'd4;
      end
    end else begin
      if (pc_inc) pc <= pc + 32'd4;
      if (ld_skid) begin
        skid_pc <= pc;
        skid_ir <= imem_rdata;
      end
      if (ld_fetch) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_ir    <= imem_rdata;
        if_npc   <= pc + 32'd4;
      end else if (unld_skid) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_ir    <= skid_ir;
        if_npc   <= skid_pc + 32'd4;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
        if_ir    <= NOP_INSTR;
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Exception flag rides with the slot: set by a misaligned redirect, cleared when that slot leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      if_exc <= 1'b0;
    else if (br_taken)              if_exc <= br_misaligned;
    else if (ld_fetch || unld_skid) if_exc <= 1'b0;
    else if (if_valid && !stall)    if_exc <= 1'b0;
  end
`else
  assign if_exc = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized stall/ack/redirect traffic.
// Reference model tracks the expected instruction stream and fetch address sequence.
// Memory returns addr | A000_0000 combinationally, accepting whenever ack is driven.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_HI = 32'hFFFF_FFF8;
  localparam logic [31:0] MEM_TAG  = 32'hA000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_exc;
  logic [31:0] if_pc, if_ir, if_npc;

  logic        hi_stall = 1'b0, hi_br = 1'b0, hi_ack = 1'b1;
  logic [31:0] hi_tgt = 32'h0;
  logic        hi_req, hi_valid, hi_exc;
  logic [31:0] hi_addr, hi_rdata, hi_pc, hi_ir, hi_npc;

  assign imem_rdata = imem_addr | MEM_TAG;
  assign hi_rdata   = hi_addr | MEM_TAG;

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir), .if_npc(if_npc), .if_exc(if_exc)
  );

  if_fetch_stage #(.RESET_PC(RESET_HI)) u_dut_hi (
    .clk(clk), .reset(reset), .stall(hi_stall), .br_taken(hi_br), .br_target(hi_tgt),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(hi_ack), .imem_rdata(hi_rdata),
    .if_valid(hi_valid), .if_pc(hi_pc), .if_ir(hi_ir), .if_npc(hi_npc), .if_exc(hi_exc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic        model_en;
  logic [31:0] exp_del, exp_fetch;   // next pc to be consumed / next useful fetch address
  logic        outst, dropping;      // request awaiting ack / that request is being discarded
  logic        pend_clear, pend_hold, pend_load, pend_stable;
  logic [31:0] hold_pc, load_pc, pend_addr;
  logic        last_req;
  logic [31:0] last_addr;
  int          n_del;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    exp_del = 32'h0; exp_fetch = 32'h0;
    outst = 1'b0; dropping = 1'b0;
    pend_clear = 1'b0; pend_hold = 1'b0; pend_load = 1'b0; pend_stable = 1'b0;
    hold_pc = 32'h0; load_pc = 32'h0; pend_addr = 32'h0;
  endtask

  // Evaluate one cycle's inputs/outputs against the stream rules, before the clock edge
  task automatic check_cycle();
    logic v, sfree, useful;
    last_req  = imem_req;
    last_addr = imem_addr;
    if (model_en) begin
      v     = if_valid;
      sfree = !v || !stall;
      if (pend_stable) begin
        chk("req_hold", {31'd0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, pend_addr);
      end
      if (v) begin
        chk("ir_data", if_ir, if_pc | MEM_TAG);
        chk("npc", if_npc, if_pc + 32'd4);
      end else begin
        chk("ir_nop", if_ir, NOP);
      end
`ifndef IF_ALIGN_CHECK_EN
      chk("exc_zero", {31'd0, if_exc}, 32'd0);
`endif
      if (v && stall && !outst) chk("req_stalled", {31'd0, imem_req}, 32'd0);
      useful = imem_req && imem_ack && !br_taken && !dropping;
      if (useful) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (v && !stall && !br_taken) begin
        chk("stream_pc", if_pc, exp_del);
        exp_del = exp_del + 32'd4;
        n_del++;
      end
      if (br_taken) begin
        exp_fetch = br_target & ~32'h3;
        exp_del   = br_target & ~32'h3;
      end
      pend_clear  = br_taken;
      pend_hold   = v && stall && !br_taken;
      hold_pc     = if_pc;
      pend_load   = useful && sfree;
      load_pc     = imem_addr;
      pend_stable = imem_req && !imem_ack && !(br_taken && !outst);
      pend_addr   = imem_addr;
      dropping    = (dropping || (br_taken && outst)) && !(imem_req && imem_ack);
      outst       = imem_req && !imem_ack && !(br_taken && !outst);
    end
  endtask

  // Check the registered slot one cycle after the events recorded by check_cycle
  task automatic check_post();
    if (model_en) begin
      if (pend_clear) chk("clear_valid", {31'd0, if_valid}, 32'd0);
      if (pend_hold) begin
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, hold_pc);
      end
      if (pend_load) begin
        chk("load_valid", {31'd0, if_valid}, 32'd1);
        chk("load_pc", if_pc, load_pc);
      end
    end
  endtask

  task automatic tick();
    #1;
    check_cycle();
    @(negedge clk);
    check_post();
  endtask

  task automatic do_reset();
    reset = 1'b1; br_taken = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_req_hi", {31'd0, hi_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_npc", if_npc, 32'h4);
    chk("rst_ir", if_ir, NOP);
    chk("rst_exc", {31'd0, if_exc}, 32'd0);
  endtask

  task automatic drive(input logic s, input logic a, input logic b, input logic [31:0] t);
    stall = s; imem_ack = a; br_taken = b; br_target = t;
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    model_en = 1'b1;
    model_init();
    n_del = 0;
    @(negedge clk);
    do_reset();

    // back-to-back fetch; the high-reset instance checks PC wrap alongside
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      cnt += int'(if_valid);
      if (k < 3) begin
        chk("hi_valid", {31'd0, hi_valid}, 32'd1);
        chk("hi_pc", hi_pc, RESET_HI + 32'd4 * k);
        chk("hi_npc", hi_npc, RESET_HI + 32'd4 * k + 32'd4);
        chk("hi_ir", hi_ir, (RESET_HI + 32'd4 * k) | MEM_TAG);
      end
    end
    chk("throughput", cnt, 10);

    // withheld ack at 0x8
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    chk("t3_req", {31'd0, last_req}, 32'd1);
    chk("t3_addr0", last_addr, 32'h8);
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    chk("t3_addr1", last_addr, 32'h8);
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("t3_addr2", last_addr, 32'h8);
    chk("t3_pc", if_pc, 32'h8);

    // redirect while waiting at 0xC
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    chk("t4_wait_addr", last_addr, 32'hC);
    drive(1'b0, 1'b0, 1'b1, 32'h100); tick();
    chk("t4_valid0", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("t4_drop_addr", last_addr, 32'hC);
    chk("t4_valid1", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("t4_new_addr", last_addr, 32'h100);
    chk("t4_pc", if_pc, 32'h100);

    // stall arriving while a request waits
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    chk("t5_wait_req", {31'd0, last_req}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0); tick();
    chk("t5_pc", if_pc, 32'h104);
    drive(1'b1, 1'b0, 1'b0, 32'h0); tick();
    chk("t5_req_off", {31'd0, last_req}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0); tick();
    chk("t5_held_pc", if_pc, 32'h104);
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("t5_next_addr", last_addr, 32'h108);

    // reset while a request is outstanding
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    do_reset();

    // randomized traffic
    n_del = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      stall    = ($urandom_range(0, 9) < 3);
      imem_ack = ($urandom_range(0, 9) < 6);
      br_taken = ($urandom_range(0, 19) == 0);
      if (r[2:0] == 3'd0) br_target = 32'hFFFF_FFF0 + {28'd0, r[6:3]};
      else                br_target = {22'd0, r[15:8], r[17:16]};
`ifdef IF_ALIGN_CHECK_EN
      br_target[1:0] = 2'b00;
`endif
      tick();
    end
    chk("progress", {31'd0, (n_del > 150)}, 32'd1);

`ifdef IF_ALIGN_CHECK_EN
    // misaligned redirect halts fetch and reports through the slot
    do_reset();
    model_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'h102); tick();
    chk("ax_exc", {31'd0, if_exc}, 32'd1);
    chk("ax_valid", {31'd0, if_valid}, 32'd1);
    chk("ax_pc", if_pc, 32'h102);
    chk("ax_ir", if_ir, NOP);
    drive(1'b1, 1'b1, 1'b0, 32'h0); tick();
    chk("ax_req_halt", {31'd0, last_req}, 32'd0);
    chk("ax_exc_held", {31'd0, if_exc}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("ax_exc_clr", {31'd0, if_exc}, 32'd0);
    chk("ax_req_halt2", {31'd0, last_req}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h200); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
    chk("ax_resume", last_addr, 32'h200);
    chk("ax_resume_pc", if_pc, 32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
